// File: rtl/alu_ctrl_seq.sv
// Sequencing controller for the 32-bit MIPS ALU: decodes ALUOp/funct, runs one or two ALU passes, returns the result.
// Optional macro ALU_CTRL_OVF_EN adds the registered rsp_ovf output.
module alu_ctrl_seq #(
  parameter logic [31:0] ERR_RES = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_aluop,
  input  logic [5:0]  req_funct,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_op,
  output logic        alu_bin,
  output logic        alu_cin,
  input  logic [31:0] alu_res,
  input  logic        alu_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_res,
  output logic [31:0] rsp_res_hi,
  output logic        rsp_zero,
  output logic        rsp_err
`ifdef ALU_CTRL_OVF_EN
  ,
  output logic        rsp_ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC_LO,
    S_EXEC_HI,
    S_RESP
  } state_e;

  typedef enum logic [2:0] {
    K_ADD,
    K_SUB,
    K_AND,
    K_OR,
    K_SLT,
    K_DADD,
    K_DSUB,
    K_ILL
  } kind_e;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;

  function automatic kind_e decode_kind(input logic [1:0] aluop, input logic [5:0] funct);
    kind_e k;
    k = K_ILL;
    case (aluop)
      2'b00: k = K_ADD;
      2'b01: k = K_SUB;
      2'b10: begin
        case (funct)
          FN_ADD:  k = K_ADD;
          FN_SUB:  k = K_SUB;
          FN_AND:  k = K_AND;
          FN_OR:   k = K_OR;
          FN_SLT:  k = K_SLT;
          default: k = K_ILL;
        endcase
      end
      default: begin
        case (funct)
          FN_ADD:  k = K_DADD;
          FN_SUB:  k = K_DSUB;
          default: k = K_ILL;
        endcase
      end
    endcase
    return k;
  endfunction

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  kind_e       req_kind;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic        carry_q, carry_d;
  logic [31:0] rsp_res_q, rsp_res_d;
  logic [31:0] rsp_res_hi_q, rsp_res_hi_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_err_q, rsp_err_d;
`ifdef ALU_CTRL_OVF_EN
  logic        rsp_ovf_q, rsp_ovf_d;
`endif

  logic [1:0]  ctl_op;
  logic        ctl_bin;
  logic        ctl_cin;
  logic        is_wide;
  logic        is_slt;
  logic        is_arith;
  logic        pass_ovf;
  logic [31:0] lo_value;

  assign req_kind = decode_kind(req_aluop, req_funct);

  // Control encoding for the latched operation; SLT reuses the subtract controls.
  always_comb begin
    ctl_op   = OP_AND;
    ctl_bin  = 1'b0;
    ctl_cin  = 1'b0;
    is_wide  = 1'b0;
    is_slt   = 1'b0;
    is_arith = 1'b0;
    case (kind_q)
      K_ADD: begin
        ctl_op   = OP_ADD;
        is_arith = 1'b1;
      end
      K_SUB: begin
        ctl_op   = OP_ADD;
        ctl_bin  = 1'b1;
        ctl_cin  = 1'b1;
        is_arith = 1'b1;
      end
      K_AND: ctl_op = OP_AND;
      K_OR:  ctl_op = OP_OR;
      K_SLT: begin
        ctl_op   = OP_ADD;
        ctl_bin  = 1'b1;
        ctl_cin  = 1'b1;
        is_slt   = 1'b1;
        is_arith = 1'b1;
      end
      K_DADD: begin
        ctl_op   = OP_ADD;
        is_wide  = 1'b1;
        is_arith = 1'b1;
      end
      K_DSUB: begin
        ctl_op   = OP_ADD;
        ctl_bin  = 1'b1;
        ctl_cin  = 1'b1;
        is_wide  = 1'b1;
        is_arith = 1'b1;
      end
      default: begin
        ctl_op = OP_AND;
      end
    endcase
  end

  // ALU drive: low words then high words; everything parked at zero outside the execute states.
  always_comb begin
    alu_a   = 32'h0;
    alu_b   = 32'h0;
    alu_op  = OP_AND;
    alu_bin = 1'b0;
    alu_cin = 1'b0;
    case (state_q)
      S_EXEC_LO: begin
        alu_a   = a_q[31:0];
        alu_b   = b_q[31:0];
        alu_op  = ctl_op;
        alu_bin = ctl_bin;
        alu_cin = ctl_cin;
      end
      S_EXEC_HI: begin
        alu_a   = a_q[63:32];
        alu_b   = b_q[63:32];
        alu_op  = ctl_op;
        alu_bin = ctl_bin;
        alu_cin = carry_q;
      end
      default: begin
        alu_a = 32'h0;
      end
    endcase
  end

  // Signed overflow of the current pass, with B taken after the Binvert stage.
  assign pass_ovf = is_arith && (alu_a[31] == (alu_b[31] ^ alu_bin)) && (alu_res[31] != alu_a[31]);
  assign lo_value = is_slt ? {31'b0, alu_res[31] ^ pass_ovf} : alu_res;

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    a_d          = a_q;
    b_d          = b_q;
    carry_d      = carry_q;
    rsp_res_d    = rsp_res_q;
    rsp_res_hi_d = rsp_res_hi_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
`ifdef ALU_CTRL_OVF_EN
    rsp_ovf_d    = rsp_ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          kind_d  = req_kind;
          a_d     = req_a;
          b_d     = req_b;
          carry_d = 1'b0;
          if (req_kind == K_ILL) begin
            state_d      = S_RESP;
            rsp_res_d    = ERR_RES;
            rsp_res_hi_d = ERR_RES;
            rsp_zero_d   = (ERR_RES == 32'h0);
            rsp_err_d    = 1'b1;
`ifdef ALU_CTRL_OVF_EN
            rsp_ovf_d    = 1'b0;
`endif
          end else begin
            state_d   = S_EXEC_LO;
            rsp_err_d = 1'b0;
          end
        end
      end
      S_EXEC_LO: begin
        rsp_res_d    = lo_value;
        rsp_res_hi_d = 32'h0;
        rsp_zero_d   = (lo_value == 32'h0);
        carry_d      = alu_cout;
`ifdef ALU_CTRL_OVF_EN
        rsp_ovf_d    = pass_ovf;
`endif
        state_d      = is_wide ? S_EXEC_HI : S_RESP;
      end
      S_EXEC_HI: begin
        rsp_res_hi_d = alu_res;
        rsp_zero_d   = (alu_res == 32'h0) && (rsp_res_q == 32'h0);
`ifdef ALU_CTRL_OVF_EN
        rsp_ovf_d    = pass_ovf;
`endif
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      kind_q       <= K_ADD;
      a_q          <= 64'h0;
      b_q          <= 64'h0;
      carry_q      <= 1'b0;
      rsp_res_q    <= 32'h0;
      rsp_res_hi_q <= 32'h0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
`ifdef ALU_CTRL_OVF_EN
      rsp_ovf_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      a_q          <= a_d;
      b_q          <= b_d;
      carry_q      <= carry_d;
      rsp_res_q    <= rsp_res_d;
      rsp_res_hi_q <= rsp_res_hi_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
`ifdef ALU_CTRL_OVF_EN
      rsp_ovf_q    <= rsp_ovf_d;
`endif
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_res    = rsp_res_q;
  assign rsp_res_hi = rsp_res_hi_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
`ifdef ALU_CTRL_OVF_EN
  assign rsp_ovf    = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq with a behavioural 32-bit MIPS ALU attached to the control outputs.
module tb_alu_ctrl_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_aluop;
  logic [5:0]  req_funct;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_op;
  logic        alu_bin;
  logic        alu_cin;
  logic [31:0] alu_res;
  logic        alu_cout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_res;
  logic [31:0] rsp_res_hi;
  logic        rsp_zero;
  logic        rsp_err;
`ifdef ALU_CTRL_OVF_EN
  logic        rsp_ovf;
`endif

  int checkCount;
  int passCount;
  logic hiCin;
  logic [31:0] hiA;

  alu_ctrl_seq #(.ERR_RES(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_aluop  (req_aluop),
    .req_funct  (req_funct),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_bin    (alu_bin),
    .alu_cin    (alu_cin),
    .alu_res    (alu_res),
    .alu_cout   (alu_cout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_res    (rsp_res),
    .rsp_res_hi (rsp_res_hi),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
`ifdef ALU_CTRL_OVF_EN
    ,
    .rsp_ovf    (rsp_ovf)
`endif
  );

  // Behavioural ALU: and / or / add with Binvert and Carryin, carry always from the adder.
  logic [31:0] modelB;
  logic [32:0] modelSum;
  always_comb begin
    modelB   = alu_bin ? ~alu_b : alu_b;
    modelSum = {1'b0, alu_a} + {1'b0, modelB} + {32'h0, alu_cin};
    alu_cout = modelSum[32];
    case (alu_op)
      2'b00:   alu_res = alu_a & modelB;
      2'b01:   alu_res = alu_a | modelB;
      default: alu_res = modelSum[31:0];
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: offer the request, measure edges to response, check it, consume it.
  task automatic applyStimulus(input string tag, input logic [1:0] aluop, input logic [5:0] funct,
                               input logic [63:0] a, input logic [63:0] b, input int expLat,
                               input logic [31:0] expRes, input logic [31:0] expHi,
                               input logic expZero, input logic chkZero, input logic expErr);
    int waitCnt;
    int lat;
    waitCnt = 0;
    while (!req_ready && waitCnt < 20) begin
      stepClock();
      waitCnt++;
    end
    if (waitCnt >= 20) checkOutput({tag, "_ready_timeout"}, 64'd0, 64'd1);
    req_valid = 1'b1;
    req_aluop = aluop;
    req_funct = funct;
    req_a     = a;
    req_b     = b;
    stepClock();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      stepClock();
      lat++;
      if (lat == 1) begin
        hiCin = alu_cin;
        hiA   = alu_a;
      end
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, "_res"}, {32'h0, rsp_res}, {32'h0, expRes});
    checkOutput({tag, "_res_hi"}, {32'h0, rsp_res_hi}, {32'h0, expHi});
    checkOutput({tag, "_err"}, {63'h0, rsp_err}, {63'h0, expErr});
    if (chkZero) checkOutput({tag, "_zero"}, {63'h0, rsp_zero}, {63'h0, expZero});
    rsp_ready = 1'b1;
    stepClock();
    rsp_ready = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    hiCin      = 1'b0;
    hiA        = 32'h0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_aluop  = 2'b00;
    req_funct  = 6'b000000;
    req_a      = 64'h0;
    req_b      = 64'h0;
    rsp_ready  = 1'b0;

    #12;
    checkOutput("rst_rsp_valid", {63'h0, rsp_valid}, 64'd0);
    checkOutput("rst_rsp_res", {32'h0, rsp_res}, 64'd0);
    checkOutput("rst_alu_op", {62'h0, alu_op}, 64'd0);
    rst_n = 1'b1;
    stepClock();
    checkOutput("rst_req_ready", {63'h0, req_ready}, 64'd1);

    applyStimulus("and", 2'b10, 6'b100100, 64'ha5a5a5a5, 64'h5a5a5a5a, 1, 32'h00000000, 32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus("or",  2'b10, 6'b100101, 64'ha5a5a5a5, 64'h5a5a5a5a, 1, 32'hffffffff, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("add", 2'b00, 6'b000000, 64'ha5a5a5a5, 64'h5a5a5a5a, 1, 32'hffffffff, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("sub", 2'b01, 6'b000000, 64'ha5a5a5a5, 64'h5a5a5a5a, 1, 32'h4b4b4b4b, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("slt_neg", 2'b10, 6'b101010, 64'hffffffff, 64'h00000001, 1, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("slt_ovf", 2'b10, 6'b101010, 64'h7fffffff, 64'h80000000, 1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus("dadd", 2'b11, 6'b100000, 64'h00000001_ffffffff, 64'h1, 2, 32'h0, 32'h2, 1'b0, 1'b1, 1'b0);
    checkOutput("dadd_hi_cin", {63'h0, hiCin}, 64'd1);
    checkOutput("dadd_hi_a", {32'h0, hiA}, 64'h1);
    applyStimulus("dsub", 2'b11, 6'b100010, 64'h0000000a_00000000, 64'h0000000a_00000000, 2, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus("illegal", 2'b10, 6'b000000, 64'h12345678, 64'h9abcdef0, 0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Backpressure: response held while a second request waits on the bus.
    req_valid = 1'b1;
    req_aluop = 2'b00;
    req_funct = 6'b000000;
    req_a     = 64'd1;
    req_b     = 64'd2;
    stepClock();
    stepClock();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", {63'h0, rsp_valid}, 64'd1);
      checkOutput("bp_res", {32'h0, rsp_res}, 64'd3);
      checkOutput("bp_req_ready", {63'h0, req_ready}, 64'd0);
      stepClock();
    end
    rsp_ready = 1'b1;
    req_a     = 64'd4;
    req_b     = 64'd5;
    stepClock();
    rsp_ready = 1'b0;
    checkOutput("bp_release_valid", {63'h0, rsp_valid}, 64'd0);
    checkOutput("bp_release_ready", {63'h0, req_ready}, 64'd1);
    stepClock();
    req_valid = 1'b0;
    checkOutput("bp_next_accepted", {63'h0, req_ready}, 64'd0);
    stepClock();
    checkOutput("bp_next_valid", {63'h0, rsp_valid}, 64'd1);
    checkOutput("bp_next_res", {32'h0, rsp_res}, 64'd9);
    rsp_ready = 1'b1;
    stepClock();
    rsp_ready = 1'b0;

    // Reset during the high pass of a wide add; low pass leaves 8 in rsp_res.
    req_valid = 1'b1;
    req_aluop = 2'b11;
    req_funct = 6'b100000;
    req_a     = 64'h00000005_00000007;
    req_b     = 64'h00000003_00000001;
    stepClock();
    req_valid = 1'b0;
    stepClock();
    checkOutput("mid_lo_res", {32'h0, rsp_res}, 64'd8);
    checkOutput("mid_hi_a", {32'h0, alu_a}, 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {63'h0, rsp_valid}, 64'd0);
    checkOutput("mid_rst_res", {32'h0, rsp_res}, 64'd0);
    checkOutput("mid_rst_res_hi", {32'h0, rsp_res_hi}, 64'd0);
    checkOutput("mid_rst_alu_a", {32'h0, alu_a}, 64'd0);
    checkOutput("mid_rst_alu_b", {32'h0, alu_b}, 64'd0);
    checkOutput("mid_rst_alu_op", {62'h0, alu_op}, 64'd0);
    stepClock();
    rst_n = 1'b1;
    stepClock();
    checkOutput("post_rst_ready", {63'h0, req_ready}, 64'd1);
    applyStimulus("add_after_rst", 2'b00, 6'b000000, 64'd2, 64'd3, 1, 32'd5, 32'h0, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Controller that drives the 32-bit MIPS ALU datapath (and/or/add with Binvert and Carryin).
- Accepts decoded-instruction requests over a valid/ready handshake and maps ALUOp/funct onto the ALU's op/bin/cin controls.
- Captures the ALU result and returns it over a valid/ready response channel.
- Sequences 64-bit add/sub as two ALU passes, feeding the low-word carry back as the high-word carry-in.

Parameters:
- ERR_RES, 32'h0000_0000: value returned on rsp_res and rsp_res_hi for an illegal ALUOp/funct.

Ports:
- clk  in  1  single clock; rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_aluop  in  2  00 add, 01 sub, 10 R-type (use funct), 11 wide R-type.
- req_funct  in  6  MIPS funct field.
- req_a  in  64  operand A; bits 63:32 used only for wide ops.
- req_b  in  64  operand B; bits 63:32 used only for wide ops.
- alu_a  out  32  to ALU a.
- alu_b  out  32  to ALU b.
- alu_op  out  2  to ALU Operation (00 and, 01 or, 10 add).
- alu_bin  out  1  to ALU Binvert.
- alu_cin  out  1  to ALU Carryin.
- alu_res  in  32  from ALU Result.
- alu_cout  in  1  from ALU CarryOut.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_res  out  32  result, low word.
- rsp_res_hi  out  32  result, high word; zero for narrow ops.
- rsp_zero  out  1  full result (narrow: 32b; wide: 64b) equals zero.
- rsp_err  out  1  illegal operation.

Behaviour:
- Decode (applied to the latched request):
  - aluop 00 or funct 100000 → ADD: op=10, bin=0, cin=0.
  - aluop 01 or funct 100010 → SUB: op=10, bin=1, cin=1.
  - funct 100100 → AND: op=00, bin=0, cin=0.
  - funct 100101 → OR: op=01, bin=0, cin=0.
  - funct 101010 → SLT: SUB controls; rsp_res = {31'b0, alu_res[31] ^ ovf}, where ovf = (a[31]!=b[31]) && (alu_res[31]!=a[31]).
  - aluop 11 with funct 100000 → DADD; aluop 11 with funct 100010 → DSUB.
  - Anything else → illegal.
- FSM states and transitions:
  - IDLE: req_ready=1. When req_valid, latch req_* and go to EXEC_LO, or to RESP if illegal.
  - EXEC_LO: drive the low words and the decoded controls. At the clock edge, capture alu_res into rsp_res and alu_cout into carry_q. Go to EXEC_HI if wide, otherwise RESP.
  - EXEC_HI: drive the high words, same op/bin, alu_cin=carry_q. Capture alu_res into rsp_res_hi. Go to RESP.
  - RESP: rsp_valid=1 and all rsp_* held stable. When rsp_ready, go to IDLE.
- Illegal request: goes IDLE→RESP directly with rsp_err=1 and rsp_res = rsp_res_hi = ERR_RES.
- Latency: request accepted at edge N → rsp_valid high after edge N+1 (narrow) or N+2 (wide). Illegal requests: after edge N.
- req_ready is low outside IDLE, so at most one request is in flight. No request is accepted in the cycle a response is consumed.
- Outside EXEC states, the ALU outputs are driven to zero: alu_op=00, bin=0, cin=0, alu_a = alu_b = 0.
- rsp_zero and rsp_err are registered together with the result.
- Reset (asynchronous, any state, including mid-wide-op): state=IDLE.
  - rsp_valid=0, rsp_res=0, rsp_res_hi=0, rsp_zero=0, rsp_err=0, carry_q=0.
  - req_ready=1 from the first cycle after release.
  - The in-flight operation is discarded.

Optional Feature:
- Macro: ALU_CTRL_OVF_EN.
- Defined: adds output port rsp_ovf (1 bit), registered with the result.
  - ADD/SUB/SLT: signed overflow of the 32b operation.
  - DADD/DSUB: signed overflow from the high pass (bit 63).
  - AND, OR and illegal ops: 0.
  - Reset value: 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- a=a5a5a5a5, b=5a5a5a5a, run AND, OR, ADD and SUB in turn (bench ALU model attached) → responses in order:
  - AND: 00000000, rsp_zero=1.
  - OR: ffffffff.
  - ADD: ffffffff.
  - SUB: 4b4b4b4b.
  - Each arrives 2 cycles after accept.
- SLT with a=ffffffff, b=00000001 → rsp_res=1. SLT with a=7fffffff, b=80000000 → rsp_res=0 (overflow-corrected).
- DADD a=00000001_ffffffff, b=1 → rsp_res_hi=00000002, rsp_res=00000000, 3 cycles after accept. EXEC_HI must show alu_cin=1.
- DSUB a=b=0000000a_00000000 → result 0, rsp_zero=1. aluop=10 with funct=000000 → rsp_err=1, result ERR_RES, 1 cycle after accept.
- Hold rsp_ready=0 for 5 cycles with req_valid held high → rsp_* stable, req_ready=0 throughout. Then rsp_ready=1 → next request accepted the following cycle.
- Assert rst_n low during EXEC_HI of a DADD → rsp_valid=0 and all outputs zero immediately. After release, a fresh ADD 2+3 returns 5.
